// File: rtl/seven_seg_scanner.sv
`default_nettype none
// ============================================================================
// seven_seg_scanner : four-digit multiplexed hex driver with frame-synchronous
//                     shadow capture of value/blank/dp. Revision 1.0
// ============================================================================
module seven_seg_scanner #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic [3:0]  blank,
  input  logic [3:0]  dp_in,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        frame_tick
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    digit_q, digit_d;
  logic          load_pend_q;
  logic          loaded_q;
  logic [15:0]   sh_value_q;
  logic [3:0]    sh_blank_q, sh_dp_q;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [3:0]    an_q, an_d;
  logic          frame_tick_q;
  logic          wrap, load, dark;
  logic [3:0]    nibble;

  function automatic logic [6:0] decode(input logic [3:0] x);
    logic [6:0] s;
    case (x)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  always_comb begin
    wrap    = (cnt_q == CNT_LAST);
    cnt_d   = wrap ? '0 : cnt_q + CW'(1);
    digit_d = digit_q + {1'b0, wrap};
    // Shadows refresh on the 3->0 digit wrap, or once right after reset.
    load    = load_pend_q | (wrap & (digit_q == 2'd3));
    nibble  = sh_value_q[{digit_q, 2'b00} +: 4];
    // First cycle of every slot is dead time to suppress ghosting.
    dark    = (cnt_q == '0) | sh_blank_q[digit_q];
    an_d    = 4'hF;
    seg_d   = 7'h7F;
    dp_d    = 1'b1;
    if (!dark) begin
      an_d  = ~(4'b0001 << digit_q);
      seg_d = decode(nibble);
      dp_d  = ~sh_dp_q[digit_q];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q        <= '0;
      digit_q      <= 2'd0;
      load_pend_q  <= 1'b1;
      loaded_q     <= 1'b0;
      sh_value_q   <= 16'h0000;
      sh_blank_q   <= 4'hF;
      sh_dp_q      <= 4'h0;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      an_q         <= 4'hF;
      frame_tick_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      digit_q      <= digit_d;
      load_pend_q  <= 1'b0;
      loaded_q     <= load;
      if (load) begin
        sh_value_q <= value;
        sh_blank_q <= blank;
        sh_dp_q    <= dp_in;
      end
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      // Aligned with the one-clock output lag of the shadow contents.
      frame_tick_q <= loaded_q;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_tick = frame_tick_q;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scanner.sv
`default_nettype none
// ============================================================================
// tb_seven_seg_scanner : directed bench for seven_seg_scanner at REFRESH_DIV=4.
// Revision 1.0
// ============================================================================
module tb_seven_seg_scanner;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] value = 16'h0000;
  logic [3:0]  blank = 4'h0;
  logic [3:0]  dp_in = 4'h0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_tick;

  int n_tests = 0;
  int n_fail  = 0;
  int n       = 0;
  logic [15:0] m_val;
  logic [3:0]  m_blank, m_dp;

  seven_seg_scanner #(.REFRESH_DIV(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .value      (value),
    .blank      (blank),
    .dp_in      (dp_in),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_tick (frame_tick)
  );

  always #5 clock = ~clock;

  function automatic logic [6:0] exp_dec(input logic [3:0] x);
    logic [6:0] t [16];
    t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
          7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
          7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
          7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    return t[x];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (edge %0d): got %h expected %h", tag, n, got, exp);
    end
  endtask

  task automatic check_dark(input string tag);
    check({tag, "_an"},  32'(an),  32'hF);
    check({tag, "_seg"}, 32'(seg), 32'h7F);
    check({tag, "_dp"},  32'(dp),  32'h1);
  endtask

  // Holds reset across one edge, checks reset outputs, releases on a negedge.
  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    check_dark("rst");
    check("rst_tick", 32'(frame_tick), 32'h0);
    @(negedge clock);
    reset   = 1'b0;
    n       = 0;
    m_val   = 16'h0000;
    m_blank = 4'hF;
    m_dp    = 4'h0;
  endtask

  // One clock edge: expected outputs come from the state before this edge.
  task automatic step();
    int         k;
    logic [1:0] d;
    logic       drk, etick;
    logic [3:0] ean;
    logic [6:0] eseg;
    logic       edp;
    n++;
    k     = n - 1;
    d     = 2'((k / 4) % 4);
    drk   = ((k % 4) == 0) || m_blank[d];
    ean   = drk ? 4'hF : ~(4'b0001 << d);
    eseg  = drk ? 7'h7F : exp_dec(m_val[4*d +: 4]);
    edp   = drk ? 1'b1 : ~m_dp[d];
    etick = (n == 2) || (n >= 17 && ((n - 17) % 16) == 0);
    if (n == 1 || (n % 16) == 0) begin
      m_val   = value;
      m_blank = blank;
      m_dp    = dp_in;
    end
    @(posedge clock);
    #1;
    check("an",   32'(an),         32'(ean));
    check("seg",  32'(seg),        32'(eseg));
    check("dp",   32'(dp),         32'(edp));
    check("tick", 32'(frame_tick), 32'(etick));
  endtask

  initial begin
    // Reset release and steady scanning of 1234
    value = 16'h1234; blank = 4'h0; dp_in = 4'h0;
    do_reset();
    step();
    check("first_an_dark", 32'(an), 32'hF);
    step();
    check("edge2_tick", 32'(frame_tick), 32'h1);
    check("edge2_an",   32'(an),         32'hE);
    check("edge2_seg4", 32'(seg),        32'b0011001);
    repeat (34) step();

    // Mid-frame change while digit 1 is active
    value = 16'h1234;
    do_reset();
    repeat (6) step();
    value = 16'hABCD;
    repeat (12) step();
    check("abcd_d_digit0", 32'(seg), 32'b0100001);
    repeat (32) step();

    // Blank and decimal point
    value = 16'h5678; blank = 4'b1010; dp_in = 4'b0001;
    do_reset();
    repeat (34) step();

    // Full decode sweep
    blank = 4'h0; dp_in = 4'h0;
    for (int i = 0; i < 16; i++) begin
      value = 16'(i * 16'h1111);
      do_reset();
      repeat (18) step();
    end

    // Asynchronous reset in cnt=2 of digit 2
    value = 16'h1234;
    do_reset();
    repeat (10) step();
    check("pre_async_an", 32'(an), 32'hB);
    #2;
    reset = 1'b1;
    #1;
    check_dark("async");
    @(negedge clock);
    reset   = 1'b0;
    n       = 0;
    m_val   = 16'h0000;
    m_blank = 4'hF;
    m_dp    = 4'h0;
    repeat (20) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
